// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the load/store unit (LS).
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that ends a stuck WAIT with an error response.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_err,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_be,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_ls_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);
    localparam int BE_W     = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mem_port_arbiter: STARVE_MAX and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t              state, state_nxt;
    owner_t              owner, owner_nxt, cur_owner;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;
    logic                mem_req;
    logic                gnt_cyc;
    logic                resp;
    logic                timeout;
    logic                if_forced;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Age of the current WAIT; held at zero outside WAIT so it starts fresh on entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            wait_cnt <= '0;
        else if (state != ST_WAIT)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_W'(TIMEOUT_CYC))
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == ST_WAIT) && !i_mem_rvalid &&
                     (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign if_forced = i_if_req && (starve_cnt == STARVE_W'(STARVE_MAX));

    // In IDLE the owner is chosen live so a same-cycle grant is possible; later it is frozen.
    always_comb begin
        cur_owner = owner;
        mem_req   = 1'b0;
        if (i_rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (i_if_req || i_ls_req) begin
                        mem_req   = 1'b1;
                        cur_owner = (i_ls_req && !if_forced) ? OWN_LS : OWN_IF;
                    end
                end
                ST_REQ:  mem_req = 1'b1;
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign gnt_cyc = mem_req && i_mem_gnt;
    assign resp    = (state == ST_WAIT) && i_mem_rvalid;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (mem_req) begin
                    owner_nxt = cur_owner;
                    state_nxt = i_mem_gnt ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ:  if (i_mem_gnt) state_nxt = ST_WAIT;
            ST_WAIT: if (resp || timeout) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (gnt_cyc) begin
            if (cur_owner == OWN_IF)
                starve_nxt = '0;
            else if (i_if_req && (starve_cnt != STARVE_W'(STARVE_MAX)))
                starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign o_mem_req   = mem_req;
    assign o_mem_we    = mem_req && (cur_owner == OWN_LS) && i_ls_we;
    assign o_mem_addr  = !mem_req ? '0 : ((cur_owner == OWN_LS) ? i_ls_addr : i_if_addr);
    assign o_mem_wdata = (mem_req && (cur_owner == OWN_LS)) ? i_ls_wdata : '0;
    assign o_mem_be    = !mem_req ? '0 : ((cur_owner == OWN_LS) ? i_ls_be : {BE_W{1'b1}});

    assign o_if_gnt    = gnt_cyc && (cur_owner == OWN_IF);
    assign o_ls_gnt    = gnt_cyc && (cur_owner == OWN_LS);

    // A watchdog expiry looks like a normal response, but with zero data and err raised.
    assign o_if_rvalid = (resp || timeout) && (owner == OWN_IF);
    assign o_ls_rvalid = (resp || timeout) && (owner == OWN_LS);
    assign o_if_rdata  = (i_rst_n && !timeout) ? i_mem_rdata : '0;
    assign o_ls_rdata  = (i_rst_n && !timeout) ? i_mem_rdata : '0;
    assign o_if_err    = timeout && (owner == OWN_IF);
    assign o_ls_err    = timeout && (owner == OWN_LS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
// With MEM_ARB_TIMEOUT_EN defined the watchdog scenario is also exercised.
module tb_mem_port_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int STARVE_MAX  = 4;
    localparam int TIMEOUT_CYC = 8;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt, o_if_rvalid, o_if_err;
    logic [DATA_W-1:0] o_if_rdata;
    logic              i_ls_req, i_ls_we;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [BE_W-1:0]   i_ls_be;
    logic              o_ls_gnt, o_ls_rvalid, o_ls_err;
    logic [DATA_W-1:0] o_ls_rdata;
    logic              o_mem_req, o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [BE_W-1:0]   o_mem_be;
    logic              i_mem_gnt, i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    int checks = 0;
    int passed = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
        .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Model: phase 0 = port free, 1 = request issued but not accepted, 2 = awaiting response.
    int m_phase  = 0;
    bit m_ls     = 1'b0;
    int m_losses = 0;
    int m_age    = 0;

    function automatic bit e_ls();
        if (m_phase != 0) return m_ls;
        return i_ls_req && !(i_if_req && m_losses >= STARVE_MAX);
    endfunction

    function automatic bit e_req();
        if (!i_rst_n) return 1'b0;
        if (m_phase == 0) return i_if_req || i_ls_req;
        return m_phase == 1;
    endfunction

    function automatic bit e_to();
`ifdef MEM_ARB_TIMEOUT_EN
        return i_rst_n && (m_phase == 2) && !i_mem_rvalid && (m_age == TIMEOUT_CYC - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit e_rsp();
        return i_rst_n && (m_phase == 2) && (i_mem_rvalid || e_to());
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_phase  <= 0;
            m_ls     <= 1'b0;
            m_losses <= 0;
            m_age    <= 0;
        end else if (e_req() && i_mem_gnt) begin
            if (!e_ls())
                m_losses <= 0;
            else if (i_if_req)
                m_losses <= (m_losses < STARVE_MAX) ? m_losses + 1 : STARVE_MAX;
            m_ls    <= e_ls();
            m_phase <= 2;
            m_age   <= 0;
        end else if (m_phase == 0 && e_req()) begin
            m_ls    <= e_ls();
            m_phase <= 1;
        end else if (m_phase == 2) begin
            if (e_rsp()) m_phase <= 0;
            m_age <= m_age + 1;
        end
    end

    // Every cycle, all outputs are compared against the model.
    always @(negedge i_clk) begin
        check_output("mem_req", o_mem_req, e_req());
        check_output("mem_we", o_mem_we, e_req() && e_ls() && i_ls_we);
        check_output("mem_addr", o_mem_addr, !e_req() ? 0 : (e_ls() ? i_ls_addr : i_if_addr));
        check_output("mem_wdata", o_mem_wdata, (e_req() && e_ls()) ? i_ls_wdata : 0);
        check_output("mem_be", o_mem_be, !e_req() ? 0 : (e_ls() ? i_ls_be : 4'hF));
        check_output("if_gnt", o_if_gnt, e_req() && i_mem_gnt && !e_ls());
        check_output("ls_gnt", o_ls_gnt, e_req() && i_mem_gnt && e_ls());
        check_output("if_rvalid", o_if_rvalid, e_rsp() && !m_ls);
        check_output("ls_rvalid", o_ls_rvalid, e_rsp() && m_ls);
        check_output("if_rdata", o_if_rdata, (i_rst_n && !e_to()) ? i_mem_rdata : 0);
        check_output("ls_rdata", o_ls_rdata, (i_rst_n && !e_to()) ? i_mem_rdata : 0);
        check_output("if_err", o_if_err, e_to() && !m_ls);
        check_output("ls_err", o_ls_err, e_to() && m_ls);
    end

    task automatic apply_stimulus(
        input bit if_req, input logic [31:0] if_addr,
        input bit ls_req, input bit ls_we, input logic [31:0] ls_addr,
        input logic [31:0] ls_wdata, input logic [3:0] ls_be,
        input bit gnt, input bit rvalid, input logic [31:0] rdata);
        @(posedge i_clk);
        #1;
        i_if_req     = if_req;
        i_if_addr    = if_addr;
        i_ls_req     = ls_req;
        i_ls_we      = ls_we;
        i_ls_addr    = ls_addr;
        i_ls_wdata   = ls_wdata;
        i_ls_be      = ls_be;
        i_mem_gnt    = gnt;
        i_mem_rvalid = rvalid;
        i_mem_rdata  = rdata;
        @(negedge i_clk);
    endtask

    bit exp_ls_win [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        i_rst_n      = 1'b0;
        i_if_req     = 1'b1;
        i_if_addr    = 32'h40;
        i_ls_req     = 1'b0;
        i_ls_we      = 1'b0;
        i_ls_addr    = '0;
        i_ls_wdata   = '0;
        i_ls_be      = '0;
        i_mem_gnt    = 1'b1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h1234;

        // Reset holds every output low even with a request and data present.
        @(negedge i_clk);
        check_output("rst_mem_req", o_mem_req, 0);
        check_output("rst_if_gnt", o_if_gnt, 0);
        check_output("rst_mem_addr", o_mem_addr, 0);
        check_output("rst_if_rdata", o_if_rdata, 0);
        @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_if_req    = 1'b0;
        i_if_addr   = '0;
        i_mem_gnt   = 1'b0;
        i_mem_rdata = '0;

        $display("[TB] single fetch");
        apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        check_output("fetch_gnt", o_if_gnt, 1);
        check_output("fetch_addr", o_mem_addr, 32'h100);
        check_output("fetch_be", o_mem_be, 4'hF);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD);
        check_output("fetch_rvalid", o_if_rvalid, 1);
        check_output("fetch_rdata", o_if_rdata, 32'hDEAD);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] contention");
        apply_stimulus(1, 32'h104, 1, 1, 32'h200, 32'h55, 4'hF, 1, 0, 0);
        check_output("cont_ls_gnt", o_ls_gnt, 1);
        check_output("cont_if_gnt", o_if_gnt, 0);
        check_output("cont_we", o_mem_we, 1);
        check_output("cont_wdata", o_mem_wdata, 32'h55);
        apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0);
        check_output("cont_ls_ack", o_ls_rvalid, 1);
        check_output("cont_if_no_rvalid", o_if_rvalid, 0);
        apply_stimulus(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0);
        check_output("cont_if_gnt_next", o_if_gnt, 1);
        check_output("cont_if_addr", o_mem_addr, 32'h104);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
        check_output("cont_if_rvalid", o_if_rvalid, 1);

        $display("[TB] starvation guard");
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1, 32'h108, 1, 0, 32'h300 + 4 * k, 0, 4'hF, 1, 0, 0);
            check_output($sformatf("starve_ls_gnt%0d", k), o_ls_gnt, exp_ls_win[k]);
            check_output($sformatf("starve_if_gnt%0d", k), o_if_gnt, !exp_ls_win[k]);
            apply_stimulus(1, 32'h108, 1, 0, 32'h300 + 4 * k, 0, 4'hF, 0, 1, k);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] grant stall");
        apply_stimulus(0, 0, 1, 0, 32'h400, 0, 4'h3, 0, 0, 0);
        check_output("stall1_addr", o_mem_addr, 32'h400);
        check_output("stall1_gnt", o_ls_gnt, 0);
        apply_stimulus(1, 32'h10C, 1, 0, 32'h400, 0, 4'h3, 0, 0, 0);
        check_output("stall2_addr", o_mem_addr, 32'h400);
        apply_stimulus(1, 32'h10C, 1, 0, 32'h400, 0, 4'h3, 0, 0, 0);
        check_output("stall3_addr", o_mem_addr, 32'h400);
        check_output("stall3_be", o_mem_be, 4'h3);
        apply_stimulus(1, 32'h10C, 1, 0, 32'h400, 0, 4'h3, 1, 0, 0);
        check_output("stall_ls_gnt", o_ls_gnt, 1);
        check_output("stall_if_gnt", o_if_gnt, 0);
        apply_stimulus(1, 32'h10C, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        check_output("stall_ls_rdata", o_ls_rdata, 32'h77);
        apply_stimulus(1, 32'h10C, 0, 0, 0, 0, 0, 1, 0, 0);
        check_output("stall_if_after", o_if_gnt, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88);

        $display("[TB] reset during WAIT");
        apply_stimulus(0, 0, 1, 0, 32'h500, 0, 4'hF, 1, 0, 0);
        check_output("rw_ls_gnt", o_ls_gnt, 1);
        @(posedge i_clk);
        #1;
        i_rst_n      = 1'b0;
        i_ls_req     = 1'b0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h99;
        @(negedge i_clk);
        check_output("rw_rst_rvalid", o_ls_rvalid, 0);
        check_output("rw_rst_rdata", o_ls_rdata, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF);
        check_output("rw_stray_ls", o_ls_rvalid, 0);
        check_output("rw_stray_if", o_if_rvalid, 0);
        apply_stimulus(1, 32'h110, 0, 0, 0, 0, 0, 1, 0, 0);
        check_output("rw_next_gnt", o_if_gnt, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11);
        check_output("rw_next_rvalid", o_if_rvalid, 1);

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] watchdog");
        apply_stimulus(0, 0, 1, 1, 32'h600, 32'h1, 4'hF, 1, 0, 0);
        check_output("to_gnt", o_ls_gnt, 1);
        for (int c = 1; c <= TIMEOUT_CYC; c++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A);
            check_output($sformatf("to_err_c%0d", c), o_ls_err, c == TIMEOUT_CYC);
            check_output($sformatf("to_rvalid_c%0d", c), o_ls_rvalid, c == TIMEOUT_CYC);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A);
        check_output("to_stray", o_ls_rvalid, 0);
`endif

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
